mest_pro_sequencer: RTL and testbench

Program sequencer and result port for the MESTPro core: the device-side end of the start/result/done handshake. On `i_start` it fetches instructions from the synchronous instruction ROM from address 0 and decodes and executes each one through the ALU. It presents each result on `o_result`/`o_valid_result` together with its flags, and raises `o_all_done` once the program has finished.

---
 rtl/mest_pro_pkg.sv | 45 ++++
 rtl/mest_pro_alu.sv | 61 ++++++
 rtl/mest_pro_sequencer.sv | 138 +++++++++++++
 tb/tb_mest_pro_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mest_pro_pkg.sv
// mest_pro_pkg: shared types and constants for the MESTPro program sequencer.
//   - opcode_e     : instruction opcodes (9..E decode as NOP)
//   - state_e      : sequencer states
//   - field LSBs   : bit positions of opcode/A/B/C inside an instruction word
//   - DATA_W       : operand/result width
package mest_pro_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OPCODE_W = 4;

  // Instruction word layout: [27:24] opcode, [23:16] A, [15:8] B, [7:0] C
  localparam int unsigned OP_LSB        = 24;
  localparam int unsigned A_LSB         = 16;
  localparam int unsigned B_LSB         = 8;
  localparam int unsigned C_LSB         = 0;
  localparam int unsigned C_W           = 8;
  localparam int unsigned USE_CARRY_BIT = 0;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Opcodes that produce a result strobe and update the carry register
  function automatic logic is_result_op(input opcode_e op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/mest_pro_alu.sv
// mest_pro_alu: purely combinational ALU for the MESTPro sequencer.
// Ports:
//   op     in  opcode_e  : operation
//   a, b   in  DATA_W    : operands
//   cin    in  1         : carry/borrow in (already gated by use_carry)
//   result out DATA_W    : operation result
//   carry  out 1         : carry (ADD), borrow (SUB), shifted-out bit (SHL/SHR)
//   zero   out 1         : result == 0
module mest_pro_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  mest_pro_pkg::opcode_e   op,
  input  logic [DATA_W-1:0]       a,
  input  logic [DATA_W-1:0]       b,
  input  logic                    cin,
  output logic [DATA_W-1:0]       result,
  output logic                    carry,
  output logic                    zero
);

  import mest_pro_pkg::*;

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] sum;

  // Operation decode; unknown opcodes yield a zero result with no carry
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b} + SUM_W'(cin);
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        // Bit DATA_W of the extended difference is the borrow
        sum    = {1'b0, a} - {1'b0, b} - SUM_W'(cin);
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mest_pro_sequencer.sv
// mest_pro_sequencer: program sequencer and result port of the MESTPro core.
// On i_start it fetches instructions from a synchronous ROM starting at
// address 0, executes each through mest_pro_alu and strobes the result.
// Ports:
//   clk            in  1                : clock, rising edge
//   i_reset        in  1                : asynchronous active-high reset
//   i_start        in  1                : start request (accepted in IDLE/DONE)
//   o_rom_addr     out ADDR_W           : instruction address
//   o_rom_en       out 1                : ROM read enable (data one cycle later)
//   i_rom_data     in  INSTRUCTION_SIZE : instruction word
//   o_result       out DATA_W           : last executed result
//   o_valid_result out 1                : one-cycle strobe per result
//   o_carry        out 1                : carry/borrow of the last result
//   o_zero_flag    out 1                : last result was zero
//   o_all_done     out 1                : program finished (held)
//   o_busy         out 1                : running, from accepted start to DONE
module mest_pro_sequencer #(
  parameter int unsigned OP_CODE_SIZE     = 4,
  parameter int unsigned DATA_W           = 8,
  parameter int unsigned INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8,
  parameter int unsigned ROM_DEPTH        = 65536,
  parameter int unsigned ADDR_W           = $clog2(ROM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  output logic [ADDR_W-1:0]           o_rom_addr,
  output logic                        o_rom_en,
  input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
  output logic [DATA_W-1:0]           o_result,
  output logic                        o_valid_result,
  output logic                        o_carry,
  output logic                        o_zero_flag,
  output logic                        o_all_done,
  output logic                        o_busy
);

  import mest_pro_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

  state_e                  state;
  logic                    carry_reg;

  logic [OP_CODE_SIZE-1:0] op_bits;
  opcode_e                 op;
  logic [DATA_W-1:0]       opnd_a;
  logic [DATA_W-1:0]       opnd_b;
  logic                    use_carry;
  logic                    unused_c_bits;

  logic [DATA_W-1:0]       alu_result;
  logic                    alu_carry;
  logic                    alu_zero;
  logic                    last_word;

  // Instruction field extraction; C[7:1] carry no meaning
  assign op_bits       = i_rom_data[OP_LSB +: OP_CODE_SIZE];
  assign op            = opcode_e'(OPCODE_W'(op_bits));
  assign opnd_a        = i_rom_data[A_LSB +: DATA_W];
  assign opnd_b        = i_rom_data[B_LSB +: DATA_W];
  assign use_carry     = i_rom_data[C_LSB + USE_CARRY_BIT];
  assign unused_c_bits = ^i_rom_data[C_LSB + 1 +: C_W - 1];

  assign last_word = (o_rom_addr == LAST_ADDR);

  mest_pro_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (opnd_a),
    .b      (opnd_b),
    .cin    (use_carry & carry_reg),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Sequencer FSM with registered outputs; o_rom_addr doubles as the PC
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      carry_reg      <= 1'b0;
      o_rom_addr     <= '0;
      o_rom_en       <= 1'b0;
      o_result       <= '0;
      o_valid_result <= 1'b0;
      o_carry        <= 1'b0;
      o_zero_flag    <= 1'b0;
      o_all_done     <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_valid_result <= 1'b0;
      o_rom_en       <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state      <= ST_FETCH;
            carry_reg  <= 1'b0;
            o_rom_addr <= '0;
            o_rom_en   <= 1'b1;
            o_all_done <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT:  state <= ST_EXEC;
        ST_EXEC: begin
          if (op == OP_HALT) begin
            state      <= ST_DONE;
            o_all_done <= 1'b1;
            o_busy     <= 1'b0;
          end else begin
            if (is_result_op(op)) begin
              carry_reg      <= alu_carry;
              o_result       <= alu_result;
              o_carry        <= alu_carry;
              o_zero_flag    <= alu_zero;
              o_valid_result <= 1'b1;
            end
            // The last ROM word executes, then the address stops there
            if (last_word) begin
              state      <= ST_DONE;
              o_all_done <= 1'b1;
              o_busy     <= 1'b0;
            end else begin
              state      <= ST_FETCH;
              o_rom_addr <= o_rom_addr + ADDR_W'(1);
              o_rom_en   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mest_pro_sequencer.sv
// tb_mest_pro_sequencer: directed bench for mest_pro_sequencer.
// Two instances: a full-depth one fed by a 16-word ROM model (HALT beyond),
// and a ROM_DEPTH=4 one for the end-of-ROM path.
module tb_mest_pro_sequencer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        start_a;
  logic        start_b;

  logic [15:0] a_addr;
  logic        a_en;
  logic [27:0] a_data;
  logic [7:0]  a_res;
  logic        a_valid, a_c, a_z, a_done, a_busy;

  logic [1:0]  b_addr;
  logic        b_en;
  logic [27:0] b_data;
  logic [7:0]  b_res;
  logic        b_valid, b_c, b_z, b_done, b_busy;

  logic [27:0] rom_a [16];
  logic [27:0] rom_b [4];

  int n_checks = 0;
  int n_pass   = 0;

  // Observed strobes ({result, carry, zero}) and their cycle numbers
  logic [9:0] s_val [$];
  int         s_cyc [$];
  logic [9:0] e_val [$];
  int         e_cyc [$];
  int         fetch_addr [$];
  int         done_cyc;
  logic       busy_c1;
  logic       done_c1;

  always #5 clk = ~clk;

  mest_pro_sequencer u_dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_start        (start_a),
    .o_rom_addr     (a_addr),
    .o_rom_en       (a_en),
    .i_rom_data     (a_data),
    .o_result       (a_res),
    .o_valid_result (a_valid),
    .o_carry        (a_c),
    .o_zero_flag    (a_z),
    .o_all_done     (a_done),
    .o_busy         (a_busy)
  );

  mest_pro_sequencer #(.ROM_DEPTH(4)) u_dut4 (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_start        (start_b),
    .o_rom_addr     (b_addr),
    .o_rom_en       (b_en),
    .i_rom_data     (b_data),
    .o_result       (b_res),
    .o_valid_result (b_valid),
    .o_carry        (b_c),
    .o_zero_flag    (b_z),
    .o_all_done     (b_done),
    .o_busy         (b_busy)
  );

  // Synchronous ROM models
  always @(posedge clk) begin
    if (a_en) a_data <= (a_addr < 16'd16) ? rom_a[a_addr[3:0]] : {4'hF, 24'h0};
    if (b_en) b_data <= rom_b[b_addr];
  end

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic [7:0] r, input logic c, input logic z, input int cyc);
    e_val.push_back({r, c, z});
    e_cyc.push_back(cyc);
  endtask

  // Pulse start on one instance and record activity until o_all_done or budget.
  // Cycle 1 is the cycle after the edge that samples start. extra_start
  // raises start again during that cycle number.
  task automatic run(input bit sel, input int budget, input int extra_start);
    logic v, c, z, dn, bz, en;
    logic [7:0] r;
    int ad;
    s_val.delete(); s_cyc.delete(); fetch_addr.delete();
    done_cyc = 0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      v  = sel ? b_valid : a_valid;
      r  = sel ? b_res   : a_res;
      c  = sel ? b_c     : a_c;
      z  = sel ? b_z     : a_z;
      dn = sel ? b_done  : a_done;
      bz = sel ? b_busy  : a_busy;
      en = sel ? b_en    : a_en;
      ad = sel ? int'(b_addr) : int'(a_addr);
      if (cyc == 1) begin busy_c1 = bz; done_c1 = dn; end
      if (en) fetch_addr.push_back(ad);
      if (v) begin s_val.push_back({r, c, z}); s_cyc.push_back(cyc); end
      if (dn) begin done_cyc = cyc; break; end
      if (cyc == extra_start) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      tick();
      start_a = 1'b0; start_b = 1'b0;
    end
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_count"}, s_val.size(), e_val.size());
    for (int i = 0; i < e_val.size() && i < s_val.size(); i++) begin
      check($sformatf("%s_val%0d", tag, i), 32'(s_val[i]), 32'(e_val[i]));
      check($sformatf("%s_cyc%0d", tag, i), s_cyc[i], e_cyc[i]);
    end
    e_val.delete(); e_cyc.delete();
  endtask

  task automatic check_fetch(input string tag, input int n);
    check({tag, "_nfetch"}, fetch_addr.size(), n);
    for (int i = 0; i < n && i < fetch_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), fetch_addr[i], i);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_addr"},  a_addr,  0);
    check({tag, "_en"},    a_en,    0);
    check({tag, "_res"},   a_res,   0);
    check({tag, "_valid"}, a_valid, 0);
    check({tag, "_carry"}, a_c,     0);
    check({tag, "_zero"},  a_z,     0);
    check({tag, "_done"},  a_done,  0);
    check({tag, "_busy"},  a_busy,  0);
  endtask

  task automatic load_p1();
    for (int i = 0; i < 16; i++) rom_a[i] = ins(4'hF, 8'h00, 8'h00, 8'h00);
    rom_a[0] = ins(4'h1, 8'hFF, 8'h01, 8'h00);
    rom_a[1] = ins(4'h1, 8'h00, 8'h00, 8'h01);
    rom_a[2] = ins(4'hF, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic expect_p1();
    expect_strobe(8'h00, 1'b1, 1'b1, 4);
    expect_strobe(8'h01, 1'b0, 1'b0, 7);
  endtask

  task automatic expect_p4();
    expect_strobe(8'h02, 1'b0, 1'b0, 4);
    expect_strobe(8'h00, 1'b1, 1'b1, 7);
    expect_strobe(8'h01, 1'b0, 1'b0, 10);
    expect_strobe(8'hFE, 1'b1, 1'b0, 13);
  endtask

  initial begin
    int nstrobe;
    int nfetch;
    i_reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    load_p1();
    rom_b[0] = ins(4'h1, 8'h01, 8'h01, 8'h01);   // 02 if carry_reg cleared
    rom_b[1] = ins(4'h7, 8'h80, 8'h00, 8'h00);   // 00 c1 z1
    rom_b[2] = ins(4'h1, 8'h00, 8'h00, 8'h01);   // 01 c0
    rom_b[3] = ins(4'h7, 8'hFF, 8'h00, 8'h00);   // FE c1

    // Reset state
    repeat (3) tick();
    check_a_reset("rst");
    check("rst4_done", b_done, 0);
    check("rst4_addr", b_addr, 0);
    i_reset = 1'b0;
    tick();
    check_a_reset("idle");

    // ADD carry chain, latency/throughput; start during EXEC of HALT ignored
    expect_p1();
    run(1'b0, 40, 9);
    check_strobes("p1");
    check_fetch("p1", 3);
    check("p1_busy_c1", busy_c1, 1);
    check("p1_done_cyc", done_cyc, 10);
    check("p1_busy_at_done", a_busy, 0);
    tick(); tick();
    check("p1_start_at_done_entry_ignored", a_done, 1);
    check("p1_no_refetch", a_en, 0);
    check("p1_result_held", a_res, 8'h01);

    // Restart from DONE with a start pulse while busy
    expect_p1();
    run(1'b0, 40, 2);
    check("p1r_done_cleared", done_c1, 0);
    check_strobes("p1r");
    check_fetch("p1r", 3);
    check("p1r_done_cyc", done_cyc, 10);

    // Ops coverage
    for (int i = 0; i < 16; i++) rom_a[i] = ins(4'hF, 8'h00, 8'h00, 8'h00);
    rom_a[0]  = ins(4'h2, 8'h03, 8'h05, 8'h00);
    rom_a[1]  = ins(4'h3, 8'hF0, 8'h3C, 8'h00);
    rom_a[2]  = ins(4'h7, 8'h81, 8'h00, 8'h00);
    rom_a[3]  = ins(4'h2, 8'h05, 8'h02, 8'h01);
    rom_a[4]  = ins(4'h8, 8'h01, 8'h00, 8'h00);
    rom_a[5]  = ins(4'hA, 8'h12, 8'h34, 8'h00);
    rom_a[6]  = ins(4'h1, 8'h10, 8'h20, 8'hFE);
    rom_a[7]  = ins(4'h4, 8'h0F, 8'hF0, 8'h00);
    rom_a[8]  = ins(4'h5, 8'hFF, 8'h0F, 8'h00);
    rom_a[9]  = ins(4'h6, 8'h55, 8'h00, 8'h00);
    expect_strobe(8'hFE, 1'b1, 1'b0, 4);
    expect_strobe(8'h30, 1'b0, 1'b0, 7);
    expect_strobe(8'h02, 1'b1, 1'b0, 10);
    expect_strobe(8'h02, 1'b0, 1'b0, 13);
    expect_strobe(8'h00, 1'b1, 1'b1, 16);
    expect_strobe(8'h30, 1'b0, 1'b0, 22);
    expect_strobe(8'hFF, 1'b0, 1'b0, 25);
    expect_strobe(8'hF0, 1'b0, 1'b0, 28);
    expect_strobe(8'hAA, 1'b0, 1'b0, 31);
    run(1'b0, 60, 0);
    check_strobes("ops");
    check("ops_done_cyc", done_cyc, 34);
    check("ops_result_held", a_res, 8'hAA);

    // Reset asserted during FETCH
    load_p1();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("mid_fetch_en", a_en, 1);
    check("mid_busy", a_busy, 1);
    i_reset = 1'b1;
    #1;
    check_a_reset("mid_rst");
    tick();
    i_reset = 1'b0;
    nstrobe = 0;
    nfetch  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_valid) nstrobe++;
      if (a_en) nfetch++;
    end
    check("mid_no_strobe", nstrobe, 0);
    check("mid_no_fetch", nfetch, 0);
    check("mid_idle_done", a_done, 0);
    check("mid_idle_busy", a_busy, 0);

    // End of ROM without HALT, run twice to show carry clears on start
    expect_p4();
    run(1'b1, 40, 0);
    check_strobes("eor");
    check_fetch("eor", 4);
    check("eor_done_cyc", done_cyc, 13);
    tick(); tick();
    check("eor_addr_stays", b_addr, 3);
    check("eor_done_held", b_done, 1);
    expect_p4();
    run(1'b1, 40, 0);
    check_strobes("eor2");
    check("eor2_done_cyc", done_cyc, 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
